// File: rtl/lane_arb_pkg.sv
// Shared types and helpers for the lane round-robin arbiter and its picker.
package lane_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_e;

   localparam int STATS_W = 16;

   // A lane index needs at least one bit even when only two lanes exist.
   function automatic int lane_idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lane_rr_arb_if.sv
// Request/downstream bundle between NUM_LANES upstream lanes, the arbiter and the shared channel.
interface lane_rr_arb_if #(
   parameter int NUM_LANES = 2,
   parameter int DATA_W    = 8
);
   import lane_arb_pkg::*;

   localparam int LANE_W = lane_idx_w(NUM_LANES);

   logic [NUM_LANES-1:0]             i_req_valid;
   logic [NUM_LANES-1:0][DATA_W-1:0] i_req_data;
   logic [NUM_LANES-1:0]             i_req_last;
   logic [NUM_LANES-1:0]             o_req_ready;
   logic                             o_out_valid;
   logic [DATA_W-1:0]                o_out_data;
   logic                             o_out_last;
   logic [LANE_W-1:0]                o_out_lane;
   logic                             i_out_ready;
   logic                             o_busy;

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_out_ready,
      input  o_req_ready, o_out_valid, o_out_data, o_out_last, o_out_lane, o_busy
   );

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_out_ready,
      output o_req_ready, o_out_valid, o_out_data, o_out_last, o_out_lane, o_busy
   );

endinterface

// File: rtl/lane_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module lane_rr_pick
   import lane_arb_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int IDX_W     = lane_idx_w(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   always_comb begin
      int slot;
      slot  = 0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         slot = int'(ptr) + i;
         if (slot >= NUM_LANES) slot = slot - NUM_LANES;
         if (!found && req[slot]) begin
            found = 1'b1;
            idx   = IDX_W'(slot);
         end
      end
   end

endmodule

// File: rtl/lane_rr_arb.sv
// Packet-granular round-robin merge of NUM_LANES lanes onto one registered output stage.
// Optional per-lane beat counters are enabled with LANE_RR_ARB_STATS_EN.
module lane_rr_arb
   import lane_arb_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   lane_rr_arb_if.slave bus
`ifdef LANE_RR_ARB_STATS_EN
   ,
   input  logic                              i_stats_clr,
   output logic [NUM_LANES-1:0][STATS_W-1:0] o_beat_cnt
`endif
);

   localparam int              LANE_W    = lane_idx_w(NUM_LANES);
   localparam logic [7:0]      BURST_END = 8'(MAX_BURST - 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

   arb_state_e          state, state_nx;
   logic [LANE_W-1:0]   ptr, ptr_nx;
   logic [LANE_W-1:0]   gnt, gnt_nx;
   logic [7:0]          beat_cnt, beat_cnt_nx;

   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic                out_last;
   logic [LANE_W-1:0]   out_lane;

   logic                load;
   logic                xfer;
   logic                end_beat;
   logic                pick_found;
   logic [LANE_W-1:0]   pick_idx;
   logic [NUM_LANES-1:0] ready;

   lane_rr_pick #(
      .NUM_LANES (NUM_LANES),
      .IDX_W     (LANE_W)
   ) u_pick (
      .req   (bus.i_req_valid),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Ready depends only on the output register and downstream ready, never on lane valid.
   assign load     = !out_valid || bus.i_out_ready;
   assign xfer     = (state == ARB_GRANT) && load && bus.i_req_valid[gnt];
   assign end_beat = bus.i_req_last[gnt] || (beat_cnt == BURST_END);

   always_comb begin
      ready = '0;
      if (state == ARB_GRANT) ready[gnt] = load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         ptr      <= '0;
         gnt      <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         gnt      <= gnt_nx;
         beat_cnt <= beat_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      gnt_nx      = gnt;
      beat_cnt_nx = beat_cnt;
      case (state)
         ARB_IDLE: begin
            if (pick_found) begin
               state_nx = ARB_GRANT;
               gnt_nx   = pick_idx;
            end
         end
         ARB_GRANT: begin
            if (xfer) begin
               if (end_beat) begin
                  state_nx    = ARB_IDLE;
                  ptr_nx      = (gnt == LAST_LANE) ? '0 : gnt + LANE_W'(1);
                  beat_cnt_nx = '0;
               end else begin
                  beat_cnt_nx = beat_cnt + 8'd1;
               end
            end
         end
         default: state_nx = ARB_IDLE;
      endcase
   end

   // The output stage drains on its own, so a released packet's last beat can linger during re-arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_lane  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= bus.i_req_data[gnt];
         out_last  <= end_beat;
         out_lane  <= gnt;
      end else if (load) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.o_req_ready = ready;
   assign bus.o_out_valid = out_valid;
   assign bus.o_out_data  = out_data;
   assign bus.o_out_last  = out_last;
   assign bus.o_out_lane  = out_lane;
   assign bus.o_busy      = (state == ARB_GRANT);

`ifdef LANE_RR_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_beat_cnt <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (i_stats_clr) begin
               o_beat_cnt[l] <= '0;
            end else if (xfer && (gnt == LANE_W'(l)) && (o_beat_cnt[l] != '1)) begin
               o_beat_cnt[l] <= o_beat_cnt[l] + 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_lane_rr_arb.sv
// Scoreboard bench for lane_rr_arb (two lanes, MAX_BURST=4); also covers LANE_RR_ARB_STATS_EN when defined.
module tb_lane_rr_arb;
   import lane_arb_pkg::*;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       lane;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   lane_rr_arb_if #(.NUM_LANES(2), .DATA_W(8)) arb ();

`ifdef LANE_RR_ARB_STATS_EN
   logic             i_stats_clr = 1'b0;
   logic [1:0][15:0] o_beat_cnt;
`endif

   lane_rr_arb #(
      .NUM_LANES (2),
      .DATA_W    (8),
      .MAX_BURST (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (arb)
`ifdef LANE_RR_ARB_STATS_EN
      ,
      .i_stats_clr (i_stats_clr),
      .o_beat_cnt  (o_beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int    testsRun = 0;
   int    testsFailed = 0;
   int    cycle = 0;
   int    laneStart [2];
   int    stallStart = -1;
   int    firstOutCycle = -1;
   int    lastOutCycle = -1;
   logic  busyLog [64];
   beat_t lane0Q [$];
   beat_t lane1Q [$];
   exp_t  expQ [$];
   int    statsExp0 = 0;
   int    statsExp1 = 0;
   bit    statsMode = 1'b0;
   bit    clrDone = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cycle);
      end
   endtask

   task automatic pushExp(input logic [7:0] d, input logic l, input logic ln);
      exp_t e;
      e.data = d;
      e.last = l;
      e.lane = ln;
      expQ.push_back(e);
   endtask

   task automatic pushBeat(input int lane, input logic [7:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      if (lane == 0) lane0Q.push_back(b);
      else           lane1Q.push_back(b);
   endtask

   task automatic applyStimulus();
      arb.i_req_valid = '0;
      arb.i_req_data  = '0;
      arb.i_req_last  = '0;
      if (cycle >= laneStart[0] && lane0Q.size() > 0) begin
         arb.i_req_valid[0] = 1'b1;
         arb.i_req_data[0]  = lane0Q[0].data;
         arb.i_req_last[0]  = lane0Q[0].last;
      end
      if (cycle >= laneStart[1] && lane1Q.size() > 0) begin
         arb.i_req_valid[1] = 1'b1;
         arb.i_req_data[1]  = lane1Q[0].data;
         arb.i_req_last[1]  = lane1Q[0].last;
      end
      arb.i_out_ready = !(stallStart >= 0 && cycle >= stallStart && cycle < stallStart + 5);
   endtask

   task automatic stepCycle();
      logic [1:0] acc;
      logic       clrSeen;
      exp_t       e;
      @(negedge clk);
      acc = arb.i_req_valid & arb.o_req_ready;
`ifdef LANE_RR_ARB_STATS_EN
      clrSeen = i_stats_clr;
`else
      clrSeen = 1'b0;
`endif
      if (cycle < 64) busyLog[cycle] = arb.o_busy;
      checkOutput("ready_onehot", 32'($countones(arb.o_req_ready) <= 1), 32'd1);
      if (arb.o_out_valid && arb.i_out_ready) begin
         if (firstOutCycle < 0) firstOutCycle = cycle;
         lastOutCycle = cycle;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", 32'(arb.o_out_valid), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_data", 32'(arb.o_out_data), 32'(e.data));
            checkOutput("out_last", 32'(arb.o_out_last), 32'(e.last));
            checkOutput("out_lane", 32'(arb.o_out_lane), 32'(e.lane));
         end
      end else if (arb.o_out_valid && expQ.size() > 0) begin
         checkOutput("stall_ready", 32'(arb.o_req_ready), 32'd0);
         checkOutput("stall_data", 32'(arb.o_out_data), 32'(expQ[0].data));
         checkOutput("stall_lane", 32'(arb.o_out_lane), 32'(expQ[0].lane));
      end
      @(posedge clk);
      #1;
      if (acc[0] && lane0Q.size() > 0) lane0Q.delete(0);
      if (acc[1] && lane1Q.size() > 0) lane1Q.delete(0);
      if (clrSeen) begin
         statsExp0 = 0;
         statsExp1 = 0;
      end else begin
         if (acc[0]) statsExp0++;
         if (acc[1]) statsExp1++;
      end
      cycle++;
`ifdef LANE_RR_ARB_STATS_EN
      if (i_stats_clr) begin
         checkOutput("stats_after_clr", 32'(o_beat_cnt[0]), 32'(statsExp0));
         i_stats_clr = 1'b0;
      end else if (statsMode && !clrDone && statsExp0 == 5) begin
         checkOutput("stats_cnt5", 32'(o_beat_cnt[0]), 32'(statsExp0));
         i_stats_clr = 1'b1;
         clrDone     = 1'b1;
      end
`endif
      applyStimulus();
   endtask

   task automatic waitQueue(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (expQ.size() > target && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput(tag, 32'(expQ.size()), 32'(target));
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      arb.i_req_valid = '0;
      arb.i_req_data  = '0;
      arb.i_req_last  = '0;
      arb.i_out_ready = 1'b1;
`ifdef LANE_RR_ARB_STATS_EN
      i_stats_clr = 1'b0;
`endif
      lane0Q.delete();
      lane1Q.delete();
      expQ.delete();
      laneStart[0]  = 0;
      laneStart[1]  = 0;
      stallStart    = -1;
      firstOutCycle = -1;
      lastOutCycle  = -1;
      statsExp0     = 0;
      statsExp1     = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      arb.i_req_valid = '0;
      arb.i_req_data  = '0;
      arb.i_req_last  = '0;
      arb.i_out_ready = 1'b1;
      #12;
      checkOutput("rst_valid", 32'(arb.o_out_valid), 32'd0);
      checkOutput("rst_data",  32'(arb.o_out_data),  32'd0);
      checkOutput("rst_last",  32'(arb.o_out_last),  32'd0);
      checkOutput("rst_lane",  32'(arb.o_out_lane),  32'd0);
      checkOutput("rst_ready", 32'(arb.o_req_ready), 32'd0);
      checkOutput("rst_busy",  32'(arb.o_busy),      32'd0);

      // Single 3-beat packet on lane 0: two-cycle latency, back-to-back beats, busy drops after the last.
      applyReset();
      for (int k = 0; k < 3; k++) begin
         pushBeat(0, 8'hA0 + 8'(k), k == 2);
         pushExp(8'hA0 + 8'(k), k == 2, 1'b0);
      end
      applyStimulus();
      waitQueue("s1_drain", 0, 40);
      repeat (3) stepCycle();
      checkOutput("s1_first_cycle", 32'(firstOutCycle), 32'd2);
      checkOutput("s1_last_cycle",  32'(lastOutCycle),  32'd4);
      checkOutput("s1_busy_mid",    32'(busyLog[3]),    32'd1);
      checkOutput("s1_busy_after",  32'(busyLog[4]),    32'd0);

      // Both lanes hold single-beat packets: grants must alternate starting at lane 0.
      applyReset();
      for (int k = 0; k < 4; k++) begin
         pushBeat(0, 8'h10 + 8'(k), 1'b1);
         pushBeat(1, 8'h18 + 8'(k), 1'b1);
         pushExp(8'h10 + 8'(k), 1'b1, 1'b0);
         pushExp(8'h18 + 8'(k), 1'b1, 1'b1);
      end
      applyStimulus();
      waitQueue("s2_drain", 0, 80);
      repeat (3) stepCycle();

      // Lane 1 streams without last; lane 0 joins at cycle 2 and gets the channel after the forced release.
      applyReset();
      laneStart[0] = 2;
      for (int k = 0; k < 10; k++) pushBeat(1, 8'h30 + 8'(k), 1'b0);
      pushBeat(0, 8'h20, 1'b0);
      pushBeat(0, 8'h21, 1'b1);
      for (int k = 0; k < 4; k++) pushExp(8'h30 + 8'(k), k == 3, 1'b1);
      pushExp(8'h20, 1'b0, 1'b0);
      pushExp(8'h21, 1'b1, 1'b0);
      for (int k = 4; k < 8; k++) pushExp(8'h30 + 8'(k), k == 7, 1'b1);
      pushExp(8'h38, 1'b0, 1'b1);
      pushExp(8'h39, 1'b0, 1'b1);
      applyStimulus();
      waitQueue("s3_drain", 0, 80);
      repeat (3) stepCycle();

      // Downstream stalls for five cycles mid-packet.
      applyReset();
      stallStart = 3;
      for (int k = 0; k < 6; k++) begin
         pushBeat(0, 8'h40 + 8'(k), k == 5);
         pushExp(8'h40 + 8'(k), (k == 3) || (k == 5), 1'b0);
      end
      applyStimulus();
      waitQueue("s4_drain", 0, 60);
      repeat (3) stepCycle();

      // Asynchronous reset in the middle of a lane 1 packet, then a simultaneous request.
      applyReset();
      pushBeat(0, 8'h50, 1'b1);
      pushExp(8'h50, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         pushBeat(1, 8'h60 + 8'(k), k == 3);
         pushExp(8'h60 + 8'(k), k == 3, 1'b1);
      end
      applyStimulus();
      waitQueue("s5_partial", 3, 40);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", 32'(arb.o_out_valid), 32'd0);
      checkOutput("arst_data",  32'(arb.o_out_data),  32'd0);
      checkOutput("arst_last",  32'(arb.o_out_last),  32'd0);
      checkOutput("arst_lane",  32'(arb.o_out_lane),  32'd0);
      checkOutput("arst_ready", 32'(arb.o_req_ready), 32'd0);
      checkOutput("arst_busy",  32'(arb.o_busy),      32'd0);
      applyReset();
      pushBeat(0, 8'h70, 1'b1);
      pushBeat(1, 8'h71, 1'b1);
      pushExp(8'h70, 1'b1, 1'b0);
      pushExp(8'h71, 1'b1, 1'b1);
      applyStimulus();
      waitQueue("s5_drain", 0, 40);
      repeat (3) stepCycle();

`ifdef LANE_RR_ARB_STATS_EN
      // Five lane 0 beats, then a clear that coincides with the sixth beat.
      applyReset();
      statsMode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pushBeat(0, 8'h80 + 8'(k), k == 2);
         pushExp(8'h80 + 8'(k), k == 2, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         pushBeat(0, 8'h90 + 8'(k), k == 3);
         pushExp(8'h90 + 8'(k), k == 3, 1'b0);
      end
      applyStimulus();
      waitQueue("stats_drain", 0, 60);
      repeat (3) stepCycle();
      statsMode = 1'b0;
      checkOutput("stats_clr_seen", 32'(clrDone), 32'd1);
      checkOutput("stats_final0", 32'(o_beat_cnt[0]), 32'(statsExp0));
      checkOutput("stats_final1", 32'(o_beat_cnt[1]), 32'(statsExp1));
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
